seg7_scan_driver: RTL and testbench
===================================

// Module: seg7_scan_driver
// PURPOSE
//   Downstream display stage for the binary/overflow counter. Accepts a 16-bit
//   binary count over a valid/ready handshake and converts it to 4 BCD digits
//   with a sequential shift-add-3 loop. Drives a 4-digit common-anode 7-segment
//   display by time-multiplexing. Replaces the single-digit hex decode, so
//   counts up to 9999 display in decimal.
// PARAMETERS
//   REFRESH_DIV  100000  clk cycles per digit slot (1 kHz/digit at 100 MHz); >=2
//   LZ_BLANK     1       1: blank leading zeros (digit 0 never blanked); 0: show all
// PORTS
//   clk          in   1   clock, rising edge
//   reset        in   1   asynchronous, active-high; clears all state
//   value_in     in   16  unsigned binary value to display
//   value_valid  in   1   value_in is offered this cycle
//   value_ready  out  1   block accepts a value (high only in IDLE)
//   seg          out  7   segments {a,b,c,d,e,f,g}, active-low, registered
//   an           out  4   digit anodes, active-low one-hot; an[0] = ones digit
//   dp           out  1   decimal point, active-low; held 1 (off)
// BEHAVIOUR
//   Reset values: seg=7'b1111111, an=4'b1111, dp=1, shown BCD=0000, ovf=0,
//     state=IDLE, value_ready=1, digit index=0, refresh count=0.
//   Reset mid-conversion aborts. Display returns to "0". No partial result shown.
//   Handshake: transfer on rising edge with value_valid & value_ready. value_ready
//     = (state==IDLE), combinational. value_valid while busy is ignored, not queued.
//   FSM: IDLE -> CONV on transfer: load shift reg, clear BCD, clear iter count.
//     Latch ovf = (value_in > 9999).
//     CONV: each cycle, add 3 to each BCD nibble >= 5, then shift {bcd,bin} left 1.
//     Stay in CONV for exactly 16 cycles (iter 0..15); on iter==15 go to DONE.
//     DONE (1 cycle): copy BCD and ovf to display regs; go to IDLE.
//   Latency: transfer at edge N -> display regs updated and value_ready=1 after
//     edge N+17. Back-to-back throughput is one value per 18 cycles.
//   Scan: refresh counter counts 0..REFRESH_DIV-1 and wraps. At wrap, digit index
//     increments 0,1,2,3,0. an and seg register from index and display regs, so
//     the outputs follow the index change by one cycle.
//     Display regs may change mid-slot; the new digit appears on the next slot edge.
//   Digit decode: 0-9 use the standard active-low patterns in the package.
//     Digit k>0 is blanked (seg=7'h7F, an still active) if LZ_BLANK=1 and digits
//     k..3 are all zero.
//   Overflow: if ovf=1, all four digits show dash (7'b1111110). No blanking applies.
//   Widths: shift reg is 32b {bcd[15:0],bin[15:0]}. Iter count is 4b.
//   65535 is the maximum input and is reported as overflow.
// STRUCTURE
//   seg7_pkg: SEG_0..SEG_9, SEG_BLANK, SEG_DASH constants; FSM state encodings
//     ST_IDLE/ST_CONV/ST_DONE; function digit_to_seg(bcd[3:0]).
//   Sub-module bin2bcd_seq: handshake and double-dabble FSM, outputs bcd[15:0],
//     ovf and done pulse. Scan, blanking and output registers stay in the top.
// TESTING  (bench uses REFRESH_DIV=4)
//   1. Reset, no input -> an=1111/seg=7F during reset.
//      Then an cycles 1110,1101,1011,0111 every 4 clk.
//      seg: SEG_0 on digit 0, 7F on digits 1-3; dp=1.
//   2. value_in=1234 valid 1 cycle -> ready low 17 cycles.
//      Digits 3..0 show 1,2,3,4 (seg 1001111,0010010,0000110,1001100).
//   3. value_in=0x270F (9999) -> all digits SEG_9.
//      Then 10000 -> all digits 1111110 (dash).
//   4. value_in=7 with LZ_BLANK=1 -> only digit 0 shows SEG_7, others 7F.
//      Repeat with LZ_BLANK=0 -> "0007".
//   5. Offer 42, then 55 while ready=0 -> 55 ignored, display 42.
//      55 offered after ready returns -> display 55.
//   6. Accept 8888, assert reset at CONV iter 8 -> outputs at reset values.
//      Display "0" after release; next transfer works normally.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared constants for the 4-digit 7-segment scan driver: active-low segment
// patterns {a,b,c,d,e,f,g}, converter FSM states and the digit decode helper.
package seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'b0000001;
  localparam logic [6:0] SEG_1     = 7'b1001111;
  localparam logic [6:0] SEG_2     = 7'b0010010;
  localparam logic [6:0] SEG_3     = 7'b0000110;
  localparam logic [6:0] SEG_4     = 7'b1001100;
  localparam logic [6:0] SEG_5     = 7'b0100100;
  localparam logic [6:0] SEG_6     = 7'b0100000;
  localparam logic [6:0] SEG_7     = 7'b0001111;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0000100;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b1111110;

  // Largest value that fits in four decimal digits.
  localparam logic [15:0] MAX_SHOWN = 16'd9999;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CONV = 2'd1,
    ST_DONE = 2'd2
  } conv_state_t;

  // BCD digit to active-low segment pattern; non-decimal codes go dark.
  function automatic logic [6:0] digit_to_seg(input logic [3:0] bcd);
    case (bcd)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/seg7_scan_driver_bin2bcd.sv
// Sequential binary-to-BCD converter (double dabble, one bit per cycle) with a
// valid/ready input handshake. Result and overflow flag are valid while done=1.
module bin2bcd_seq
  import seg7_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] value_in,
  input  logic        value_valid,
  output logic        value_ready,
  output logic [15:0] bcd,
  output logic        ovf,
  output logic        done
);

  conv_state_t state_reg;
  logic [31:0] shift_reg;      // {bcd[15:0], bin[15:0]}
  logic [3:0]  iter_reg;
  logic        ovf_reg;
  logic [31:0] adjusted;

  // Add-3 correction on every BCD nibble that is 5 or more, before the shift.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_adj
      logic [3:0] nib;
      assign nib = shift_reg[16 + 4*gi +: 4];
      assign adjusted[16 + 4*gi +: 4] = (nib >= 4'd5) ? nib + 4'd3 : nib;
    end
  endgenerate
  assign adjusted[15:0] = shift_reg[15:0];

  // Converter FSM: load on transfer, 16 adjust/shift steps, one-cycle done.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= ST_IDLE;
      shift_reg <= '0;
      iter_reg  <= '0;
      ovf_reg   <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (value_valid) begin
            shift_reg <= {16'h0000, value_in};
            iter_reg  <= '0;
            ovf_reg   <= (value_in > MAX_SHOWN);
            state_reg <= ST_CONV;
          end
        end
        ST_CONV: begin
          shift_reg <= adjusted << 1;
          iter_reg  <= iter_reg + 4'd1;
          if (iter_reg == 4'd15) begin
            state_reg <= ST_DONE;
          end
        end
        ST_DONE: begin
          state_reg <= ST_IDLE;
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign value_ready = (state_reg == ST_IDLE);
  assign done        = (state_reg == ST_DONE);
  assign bcd         = shift_reg[31:16];
  assign ovf         = ovf_reg;

endmodule

// File: rtl/seg7_scan_driver.sv
// Four-digit common-anode 7-segment driver: converts an accepted 16-bit value
// to decimal and time-multiplexes the digits, one slot of REFRESH_DIV cycles each.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int REFRESH_DIV = 100000,
  parameter bit LZ_BLANK    = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] value_in,
  input  logic        value_valid,
  output logic        value_ready,
  output logic [6:0]  seg,
  output logic [3:0]  an,
  output logic        dp
);

  localparam int CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

  logic [15:0]      conv_bcd;
  logic             conv_ovf;
  logic             conv_done;
  logic [CNT_W-1:0] refresh_cnt_reg;
  logic [1:0]       digit_idx_reg;
  logic             slot_load_reg;
  logic [15:0]      disp_bcd_reg;
  logic             disp_ovf_reg;
  logic [6:0]       seg_reg;
  logic [3:0]       an_reg;
  logic             wrap;
  logic [6:0]       digit_seg [4];

  bin2bcd_seq u_conv (
    .clk         (clk),
    .reset       (reset),
    .value_in    (value_in),
    .value_valid (value_valid),
    .value_ready (value_ready),
    .bcd         (conv_bcd),
    .ovf         (conv_ovf),
    .done        (conv_done)
  );

  assign wrap = (refresh_cnt_reg == CNT_LAST);

  // Slot timer: advance the digit index each time the refresh counter wraps.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      refresh_cnt_reg <= '0;
      digit_idx_reg   <= 2'd0;
      slot_load_reg   <= 1'b1;
    end else begin
      slot_load_reg <= wrap;
      if (wrap) begin
        refresh_cnt_reg <= '0;
        digit_idx_reg   <= digit_idx_reg + 2'd1;
      end else begin
        refresh_cnt_reg <= refresh_cnt_reg + CNT_W'(1);
      end
    end
  end

  // Capture a finished conversion into the display registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      disp_bcd_reg <= '0;
      disp_ovf_reg <= 1'b0;
    end else if (conv_done) begin
      disp_bcd_reg <= conv_bcd;
      disp_ovf_reg <= conv_ovf;
    end
  end

  // Per-digit pattern: dash on overflow, otherwise leading-zero blanking, else decode.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_digit
      logic [3:0] nibble;
      logic       upper_zero;
      assign nibble = disp_bcd_reg[4*gi +: 4];
      if (gi == 0) begin : g_ones
        assign upper_zero = 1'b0;
      end else begin : g_upper
        assign upper_zero = (disp_bcd_reg[15:4*gi] == '0);
      end
      assign digit_seg[gi] = disp_ovf_reg             ? SEG_DASH  :
                             (LZ_BLANK && upper_zero) ? SEG_BLANK :
                             digit_to_seg(nibble);
    end
  endgenerate

  // Output registers reload one cycle after each slot change, so a new value
  // shows up at the next slot boundary rather than mid-slot.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seg_reg <= SEG_BLANK;
      an_reg  <= 4'b1111;
    end else if (slot_load_reg) begin
      seg_reg <= digit_seg[digit_idx_reg];
      an_reg  <= ~(4'b0001 << digit_idx_reg);
    end
  end

  assign seg = seg_reg;
  assign an  = an_reg;
  assign dp  = 1'b1;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: two instances (leading-zero blanking on and off)
// share clock, reset and input; table vectors, hand sequences and random values.
module tb_seg7_scan_driver;

  localparam int DIV = 4;

  localparam logic [6:0] P0 = 7'b0000001, P1 = 7'b1001111, P2 = 7'b0010010,
                         P3 = 7'b0000110, P4 = 7'b1001100, P5 = 7'b0100100,
                         P6 = 7'b0100000, P7 = 7'b0001111, P8 = 7'b0000000,
                         P9 = 7'b0000100, PB = 7'b1111111, PD = 7'b1111110;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] value_in;
  logic        value_valid;
  logic        ready_a, ready_b;
  logic [6:0]  seg_a, seg_b;
  logic [3:0]  an_a, an_b;
  logic        dp_a, dp_b;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int          value;
    logic [27:0] exp_lz;   // {d3,d2,d1,d0} with leading-zero blanking
    logic [27:0] exp_all;  // {d3,d2,d1,d0} without blanking
  } vec_t;

  vec_t tbl [8];

  always #5 clk = ~clk;

  seg7_scan_driver #(.REFRESH_DIV(DIV), .LZ_BLANK(1'b1)) dut (
    .clk(clk), .reset(reset), .value_in(value_in), .value_valid(value_valid),
    .value_ready(ready_a), .seg(seg_a), .an(an_a), .dp(dp_a)
  );

  seg7_scan_driver #(.REFRESH_DIV(DIV), .LZ_BLANK(1'b0)) dut_nb (
    .clk(clk), .reset(reset), .value_in(value_in), .value_valid(value_valid),
    .value_ready(ready_b), .seg(seg_b), .an(an_b), .dp(dp_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [6:0] pat(input int d);
    case (d)
      0: return P0; 1: return P1; 2: return P2; 3: return P3; 4: return P4;
      5: return P5; 6: return P6; 7: return P7; 8: return P8; default: return P9;
    endcase
  endfunction

  // Reference: decimal digits by arithmetic, dash above 9999, blank leading zeros.
  function automatic logic [6:0] model_seg(input int v, input int k, input bit lz);
    int p;
    p = 1;
    for (int j = 0; j < k; j++) p = p * 10;
    if (v > 9999) return PD;
    if (lz && k > 0 && v < p) return PB;
    return pat((v / p) % 10);
  endfunction

  task automatic wait_ready();
    int n;
    n = 0;
    while (ready_a !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("wait_ready", ready_a, 1);
  endtask

  // Offer v for one cycle (block is idle) and measure how long ready stays low.
  task automatic send_timed(input int v);
    int n;
    @(negedge clk);
    value_in    = 16'(v);
    value_valid = 1'b1;
    @(negedge clk);
    value_valid = 1'b0;
    n = 0;
    while (ready_a !== 1'b1 && n < 60) begin
      n++;
      @(negedge clk);
    end
    check($sformatf("ready_low_cycles v=%0d", v), n, 17);
    check($sformatf("ready_b v=%0d", v), ready_b, 1);
    $display("txn value=%0d ready_low=%0d", v, n);
  endtask

  // Let the current slots finish, then sample a full scan and compare every digit.
  task automatic check_display(input int v, input logic [27:0] exp_lz, input logic [27:0] exp_all);
    int k;
    logic [3:0] seen;
    seen = 4'b0000;
    repeat (2*DIV) @(negedge clk);
    for (int i = 0; i < 4*DIV; i++) begin
      @(negedge clk);
      case (an_a)
        4'b1110: k = 0;
        4'b1101: k = 1;
        4'b1011: k = 2;
        4'b0111: k = 3;
        default: k = -1;
      endcase
      if (k < 0) begin
        check($sformatf("an_onehot v=%0d", v), an_a, 4'b1110);
      end else begin
        seen[k] = 1'b1;
        check($sformatf("seg_lz v=%0d k=%0d", v, k), seg_a, exp_lz[7*k +: 7]);
        check($sformatf("seg_all v=%0d k=%0d", v, k), seg_b, exp_all[7*k +: 7]);
        check($sformatf("an_b v=%0d", v), an_b, an_a);
      end
      check("dp", {dp_a, dp_b}, 2'b11);
    end
    check($sformatf("digits_seen v=%0d", v), seen, 4'b1111);
    $display("display value=%0d checked", v);
  endtask

  function automatic logic [27:0] model_word(input int v, input bit lz);
    logic [27:0] w;
    for (int k = 0; k < 4; k++) w[7*k +: 7] = model_seg(v, k, lz);
    return w;
  endfunction

  initial begin
    logic [3:0] exp_an;
    int v;

    tbl[0] = '{1234,  {P1, P2, P3, P4}, {P1, P2, P3, P4}};
    tbl[1] = '{9999,  {P9, P9, P9, P9}, {P9, P9, P9, P9}};
    tbl[2] = '{10000, {PD, PD, PD, PD}, {PD, PD, PD, PD}};
    tbl[3] = '{7,     {PB, PB, PB, P7}, {P0, P0, P0, P7}};
    tbl[4] = '{65535, {PD, PD, PD, PD}, {PD, PD, PD, PD}};
    tbl[5] = '{1000,  {P1, P0, P0, P0}, {P1, P0, P0, P0}};
    tbl[6] = '{305,   {PB, P3, P0, P5}, {P0, P3, P0, P5}};
    tbl[7] = '{0,     {PB, PB, PB, P0}, {P0, P0, P0, P0}};

    // Reset state
    reset = 1'b1;
    value_in = 16'h0;
    value_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_an", an_a, 4'b1111);
    check("reset_seg", seg_a, 7'h7F);
    check("reset_dp", dp_a, 1);
    check("reset_ready", ready_a, 1);
    reset = 1'b0;

    // Scan order after reset: each anode held DIV cycles, blank display shows "0"
    for (int i = 1; i <= 4*DIV; i++) begin
      @(negedge clk);
      exp_an = ~(4'b0001 << ((i - 1) / DIV));
      check($sformatf("scan_an i=%0d", i), an_a, exp_an);
      check($sformatf("scan_seg i=%0d", i), seg_a, tbl[7].exp_lz[7*((i-1)/DIV) +: 7]);
      check($sformatf("scan_seg_nb i=%0d", i), seg_b, P0);
    end

    // Table vectors
    for (int i = 0; i < 8; i++) begin
      send_timed(tbl[i].value);
      check_display(tbl[i].value, tbl[i].exp_lz, tbl[i].exp_all);
    end

    // Value offered while busy is dropped, not queued
    @(negedge clk);
    value_in = 16'd42;
    value_valid = 1'b1;
    @(negedge clk);
    value_in = 16'd55;
    repeat (5) @(negedge clk);
    value_valid = 1'b0;
    wait_ready();
    check_display(42, model_word(42, 1'b1), model_word(42, 1'b0));
    send_timed(55);
    check_display(55, model_word(55, 1'b1), model_word(55, 1'b0));

    // Reset in the middle of a conversion
    @(negedge clk);
    value_in = 16'd8888;
    value_valid = 1'b1;
    @(negedge clk);
    value_valid = 1'b0;
    repeat (8) @(negedge clk);
    reset = 1'b1;
    #1;
    check("midreset_an", an_a, 4'b1111);
    check("midreset_seg", seg_a, 7'h7F);
    check("midreset_ready", ready_a, 1);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    wait_ready();
    check_display(0, tbl[7].exp_lz, tbl[7].exp_all);
    send_timed(8888);
    check_display(8888, model_word(8888, 1'b1), model_word(8888, 1'b0));

    // Random values against the arithmetic reference
    for (int r = 0; r < 20; r++) begin
      if ($urandom_range(0, 3) == 0) v = int'($urandom_range(10000, 65535));
      else v = int'($urandom_range(0, 9999));
      repeat ($urandom_range(0, 3)) @(negedge clk);
      send_timed(v);
      check_display(v, model_word(v, 1'b1), model_word(v, 1'b0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
